// File: rtl/mod_m_prog_counter_pkg.sv
// Shared definitions for the programmable mod-M counter: direction encoding and build defaults.
// MOD_M_WRAP_TALLY_EN is undefined by default; define it to build the wrap tally and its ports.
package mod_m_prog_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned N_DEF = 8;
    localparam int unsigned M_DEF = 10;
`ifdef MOD_M_WRAP_TALLY_EN
    localparam int unsigned W_DEF = 8;
`endif

endpackage

// File: rtl/mod_m_wrap_tally.sv
// Saturating W-bit wrap counter with sticky overflow; present only when MOD_M_WRAP_TALLY_EN is defined.
// Updates on the edge after i_inc; no backpressure.
`ifdef MOD_M_WRAP_TALLY_EN
module mod_m_wrap_tally #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_ovf
);

    logic [W-1:0] r_cnt;
    logic         r_ovf;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_inc) begin
            // A wrap arriving while already saturated is what marks overflow.
            if (&r_cnt) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule
`endif

// File: rtl/mod_m_prog_counter.sv
// Programmable mod-M up/down counter with clear/load and combinational terminal/zero/wrap ticks.
// q updates one edge after controls are sampled; ticks are zero-latency; no backpressure. Tally under MOD_M_WRAP_TALLY_EN.
module mod_m_prog_counter
    import mod_m_prog_counter_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned M = M_DEF
`ifdef MOD_M_WRAP_TALLY_EN
    ,
    parameter int unsigned W = W_DEF
`endif
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic         i_up,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [N-1:0] i_load_val,
    input  logic         i_m_wr,
    input  logic [N-1:0] i_m_in,
    output logic [N-1:0] o_q,
    output logic [N-1:0] o_m_cur,
    output logic         o_max_tick,
    output logic         o_min_tick,
    output logic         o_wrap_tick
`ifdef MOD_M_WRAP_TALLY_EN
    ,
    output logic [W-1:0] o_wrap_cnt,
    output logic         o_wrap_ovf
`endif
);

    // M == 2**N truncates to 0, which is the encoding for the full 2**N range.
    localparam logic [N:0]   M_FULL = (N+1)'(M);
    localparam logic [N-1:0] M_RST  = M_FULL[N-1:0];

    logic [N-1:0] r_q;
    logic [N-1:0] r_m;

    logic [N:0]   w_m_eff;
    logic [N:0]   w_m_top;
    logic [N-1:0] w_top_n;
    logic [N:0]   w_q_ext;
    logic         w_max;
    logic         w_min;
    logic         w_oor;
    logic         w_dir_up;
    logic         w_dir_dn;
    logic [N-1:0] w_load_sat;
    logic [N-1:0] w_q_nxt;
    logic         w_wrap;

    // One extra bit so a modulus of 2**N and its top value never overflow.
    assign w_m_eff  = (r_m == '0) ? {1'b1, {N{1'b0}}} : {1'b0, r_m};
    assign w_m_top  = w_m_eff - (N+1)'(1);
    assign w_top_n  = w_m_top[N-1:0];
    assign w_q_ext  = {1'b0, r_q};
    assign w_max    = (w_q_ext >= w_m_top);
    assign w_oor    = (w_q_ext > w_m_top);
    assign w_min    = (r_q == '0);
    assign w_dir_up = (i_up == DIR_UP);
    assign w_dir_dn = (i_up == DIR_DOWN);

    assign w_load_sat = ({1'b0, i_load_val} > w_m_top) ? w_top_n : i_load_val;

    always_comb begin
        w_q_nxt = r_q;
        if (i_clr) begin
            w_q_nxt = '0;
        end else if (i_load) begin
            w_q_nxt = w_load_sat;
        end else if (i_en) begin
            if (w_dir_up) begin
                w_q_nxt = w_max ? '0 : r_q + N'(1);
            end else begin
                w_q_nxt = (w_min || w_oor) ? w_top_n : r_q - N'(1);
            end
        end
    end

    assign w_wrap = i_en & ~i_clr & ~i_load &
                    ((w_dir_up & w_max) | (w_dir_dn & (w_min | w_oor)));

    // Modulus writes land independently of counting, which still sees the old modulus this edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_q <= '0;
            r_m <= M_RST;
        end else begin
            r_q <= w_q_nxt;
            if (i_m_wr) begin
                r_m <= i_m_in;
            end
        end
    end

    assign o_q         = r_q;
    assign o_m_cur     = r_m;
    assign o_max_tick  = w_max;
    assign o_min_tick  = w_min;
    assign o_wrap_tick = w_wrap;

`ifdef MOD_M_WRAP_TALLY_EN
    mod_m_wrap_tally #(
        .W (W)
    ) u_wrap_tally (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_clr),
        .i_inc   (w_wrap),
        .o_cnt   (o_wrap_cnt),
        .o_ovf   (o_wrap_ovf)
    );
`endif

endmodule

// File: tb/tb_mod_m_prog_counter.sv
// Scoreboard bench for mod_m_prog_counter (N=4, M=10; W=2 when the wrap tally is built).
module tb_mod_m_prog_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up, clr, ld, mwr;
    logic [3:0] lv, mi;
    logic [3:0] q, m_cur;
    logic       max_t, min_t, wrap_t;
`ifdef MOD_M_WRAP_TALLY_EN
    logic [1:0] wcnt;
    logic       wovf;
`endif

    always #5 clk = ~clk;

    mod_m_prog_counter #(
        .N (4),
        .M (10)
`ifdef MOD_M_WRAP_TALLY_EN
        ,
        .W (2)
`endif
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_en        (en),
        .i_up        (up),
        .i_clr       (clr),
        .i_load      (ld),
        .i_load_val  (lv),
        .i_m_wr      (mwr),
        .i_m_in      (mi),
        .o_q         (q),
        .o_m_cur     (m_cur),
        .o_max_tick  (max_t),
        .o_min_tick  (min_t),
        .o_wrap_tick (wrap_t)
`ifdef MOD_M_WRAP_TALLY_EN
        ,
        .o_wrap_cnt  (wcnt),
        .o_wrap_ovf  (wovf)
`endif
    );

    typedef struct {
        string      nm;
        logic [3:0] q;
        logic [3:0] m;
        logic       mx;
        logic       mn;
        logic       wr;
        logic       tv;
        logic [1:0] cnt;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares the pending expectation against what the DUT presents mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.nm, ".q"},    8'(q),      8'(mon_e.q));
            chk({mon_e.nm, ".m"},    8'(m_cur),  8'(mon_e.m));
            chk({mon_e.nm, ".max"},  8'(max_t),  8'(mon_e.mx));
            chk({mon_e.nm, ".min"},  8'(min_t),  8'(mon_e.mn));
            chk({mon_e.nm, ".wrap"}, 8'(wrap_t), 8'(mon_e.wr));
`ifdef MOD_M_WRAP_TALLY_EN
            if (mon_e.tv) begin
                chk({mon_e.nm, ".wcnt"}, 8'(wcnt), 8'(mon_e.cnt));
                chk({mon_e.nm, ".wovf"}, 8'(wovf), 8'(mon_e.ovf));
            end
`endif
        end
    end

    // Drive one cycle of controls and queue the outputs expected while they are applied.
    task automatic cyc(input logic en_i, input logic up_i, input logic clr_i, input logic ld_i,
                       input logic [3:0] lv_i, input logic mwr_i, input logic [3:0] mi_i,
                       input logic [3:0] eq, input logic [3:0] em,
                       input logic emx, input logic emn, input logic ewr,
                       input logic etv, input logic [1:0] ecnt, input logic eovf,
                       input string nm);
        @(posedge clk);
        #1;
        en  = en_i;
        up  = up_i;
        clr = clr_i;
        ld  = ld_i;
        lv  = lv_i;
        mwr = mwr_i;
        mi  = mi_i;
        sb.push_back('{nm, eq, em, emx, emn, ewr, etv, ecnt, eovf});
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        en = 0; up = 0; clr = 0; ld = 0; lv = '0; mwr = 0; mi = '0;

        cyc(0,1,0,0,0,0,0, 0,10, 0,1,0, 1,0,0, "reset");
        rst_n = 1'b1;

        // Count up through the modulus and wrap.
        for (int i = 0; i < 12; i++)
            cyc(1,1,0,0,0,0,0, 4'(i % 10),10, (i % 10) == 9,(i % 10) == 0,(i % 10) == 9, 0,0,0, "up10");

        // Count down from zero, then a saturating load.
        cyc(0,0,1,0,0,0,0, 2,10, 0,0,0, 0,0,0, "clr");
        cyc(1,0,0,0,0,0,0, 0,10, 0,1,1, 0,0,0, "dn0");
        cyc(1,0,0,0,0,0,0, 9,10, 1,0,0, 0,0,0, "dn9");
        cyc(1,0,0,0,0,0,0, 8,10, 0,0,0, 0,0,0, "dn8");
        cyc(1,0,0,0,0,0,0, 7,10, 0,0,0, 0,0,0, "dn7");
        cyc(0,0,0,1,15,0,0, 6,10, 0,0,0, 0,0,0, "ld15");

        // Shrink modulus below q: up recovers to 0, down recovers to m-1.
        cyc(0,1,0,1,7,0,0,  9,10, 1,0,0, 0,0,0, "sat9");
        cyc(0,1,0,0,0,1,5,  7,10, 0,0,0, 0,0,0, "mwr5");
        cyc(0,1,0,0,0,0,0,  7,5,  1,0,0, 0,0,0, "oor_hold");
        cyc(1,1,0,0,0,0,0,  7,5,  1,0,1, 0,0,0, "oor_up");
        cyc(0,1,0,0,0,1,10, 0,5,  0,1,0, 0,0,0, "up_fix");
        cyc(0,1,0,1,7,0,0,  0,10, 0,1,0, 0,0,0, "ld7");
        cyc(0,1,0,0,0,1,5,  7,10, 0,0,0, 0,0,0, "mwr5b");
        cyc(1,0,0,0,0,0,0,  7,5,  1,0,1, 0,0,0, "oor_dn");
        cyc(0,0,0,0,0,0,0,  4,5,  1,0,0, 0,0,0, "dn_fix");

        // Priority and free-running 2**N modulus.
        cyc(1,1,1,1,3,0,0,  4,5,  1,0,0, 0,0,0, "prio_clr");
        cyc(1,1,0,1,3,0,0,  0,5,  0,1,0, 0,0,0, "prio_ld");
        cyc(0,1,0,0,0,1,0,  3,5,  0,0,0, 0,0,0, "mwr0");
        cyc(0,1,1,0,0,0,0,  3,0,  0,0,0, 0,0,0, "clr16");
        for (int i = 0; i < 17; i++)
            cyc(1,1,0,0,0,0,0, 4'(i % 16),0, (i % 16) == 15,(i % 16) == 0,(i % 16) == 15, 0,0,0, "up16");

        // Modulus 1: q pinned at 0 and every enabled cycle wraps.
        cyc(0,1,0,0,0,1,1,  1,0,  0,0,0, 0,0,0, "mwr1");
        cyc(1,1,0,0,0,0,0,  1,1,  1,0,1, 0,0,0, "m1_oor");
        cyc(1,1,0,0,0,0,0,  0,1,  1,1,1, 0,0,0, "m1_a");
        cyc(1,1,0,0,0,0,0,  0,1,  1,1,1, 0,0,0, "m1_b");
        cyc(1,0,0,0,0,0,0,  0,1,  1,1,1, 0,0,0, "m1_dn");
        cyc(1,1,0,0,0,1,0,  0,1,  1,1,1, 0,0,0, "m1_wr0");
        cyc(1,1,0,0,0,0,0,  0,0,  0,1,0, 0,0,0, "run0");
        cyc(1,1,0,0,0,0,0,  1,0,  0,0,0, 0,0,0, "run1");
        cyc(1,1,0,0,0,0,0,  2,0,  0,0,0, 0,0,0, "run2");

        // Asynchronous reset between edges while counting.
        @(posedge clk);
        #2;
        chk("async_pre.q", 8'(q), 8'd3);
        rst_n = 1'b0;
        #1;
        chk("async.q", 8'(q), 8'd0);
        chk("async.m", 8'(m_cur), 8'd10);
        chk("async.min", 8'(min_t), 8'd1);
        en = 1'b0;
        #2;
        rst_n = 1'b1;

        // Modulus 2 wraps every other cycle; tally saturates at 3 then flags overflow.
        cyc(0,1,0,0,0,1,2,  0,10, 0,1,0, 1,0,0, "mwr2");
        for (int i = 0; i < 8; i++)
            cyc(1,1,0,0,0,0,0, 4'(i % 2),2, (i % 2) == 1,(i % 2) == 0,(i % 2) == 1, 1,2'(i / 2),0, "tally");
        cyc(1,1,1,0,0,0,0,  0,2,  0,1,0, 1,3,1, "tally_ovf");
        cyc(0,1,0,0,0,0,0,  0,2,  0,1,0, 1,0,0, "tally_clr");

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
